// File: rtl/loba_div_seq_if.sv
// Valid/ready bundle for the LOBA approximate divider.
// The master drives operands and out_ready; the slave (divider) returns the quotient.
interface loba_div_seq_if #(
  parameter int N = 16
) ();
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] in_d;
  logic [N-1:0]   in_a;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_q;
  logic           out_sat;
  logic           out_dz;

  modport master (
    output in_valid, in_d, in_a, out_ready,
    input  in_ready, out_valid, out_q, out_sat, out_dz
  );

  modport slave (
    input  in_valid, in_d, in_a, out_ready,
    output in_ready, out_valid, out_q, out_sat, out_dz
  );
endinterface

// File: rtl/loba_div_seq.sv
// Sequential approximate divider, the inverse of the LOBA multiplier: Q ~= D / A using only
// the top K bits of A, one restoring-division quotient bit per cycle.
module loba_div_seq #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic            clk,
  input  logic            rst,
  loba_div_seq_if.slave   bus
);
  localparam int W2 = 2 * N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(W2);
  localparam logic [KW-1:0] KM1  = KW'(K - 1);
  localparam logic [CW-1:0] LAST = CW'(W2 - 1);

  typedef enum logic [1:0] {IDLE, NORM, DIV, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W2-1:0]   w;
  logic [W2-1:0]   quo;
  logic [W2-1:0]   quo_nxt;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    q_reg;
  logic            sat_reg;
  logic            dz_reg;
  logic [K-1:0]    ah;
  logic [K-1:0]    ah_c;
  logic [K-1:0]    r;
  logic [K-1:0]    r_nxt;
  logic [K:0]      r_shift;
  logic [CW-1:0]   count;
  logic [KW-1:0]   kh;
  logic [KW-1:0]   s_c;
  logic            qbit;
  logic            sat_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = NORM;
      NORM:    state_nxt = (a_reg == '0) ? DONE : DIV;
      DIV:     if (count == '0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Remainder stays below Ah, so K bits hold it; only the shifted partial remainder needs K+1.
  always_comb begin
    kh = '0;
    for (int i = 0; i < N; i++) begin
      if (a_reg[i]) kh = i[KW-1:0];
    end
    s_c     = (kh >= KM1) ? kh - KM1 : '0;
    ah_c    = K'(a_reg >> s_c);
    r_shift = {r, w[count]};
    qbit    = (r_shift >= {1'b0, ah});
    r_nxt   = qbit ? K'(r_shift - {1'b0, ah}) : K'(r_shift);
    quo_nxt = W2'({quo, qbit});
    sat_c   = |quo_nxt[W2-1:N];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w       <= '0;
      quo     <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      sat_reg <= 1'b0;
      dz_reg  <= 1'b0;
      ah      <= '0;
      r       <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            w     <= bus.in_d;
            a_reg <= bus.in_a;
          end
        end
        NORM: begin
          w     <= w >> s_c;
          ah    <= ah_c;
          r     <= '0;
          quo   <= '0;
          count <= LAST;
          if (a_reg == '0) begin
            q_reg   <= '1;
            sat_reg <= 1'b0;
            dz_reg  <= 1'b1;
          end
        end
        DIV: begin
          r     <= r_nxt;
          quo   <= quo_nxt;
          count <= count - CW'(1);
          if (count == '0) begin
            q_reg   <= sat_c ? '1 : quo_nxt[N-1:0];
            sat_reg <= sat_c;
            dz_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_q     = q_reg;
  assign bus.out_sat   = sat_reg;
  assign bus.out_dz    = dz_reg;
endmodule
